// File: rtl/serial_addr_decoder_if.sv
// Request-side bus bundle between a serial master, the address decoder and three slaves.
// The decoder sits on the slave modport; the driving agent uses the master modport.
interface serial_addr_decoder_if;
   logic       m_valid;
   logic       m_wdata;
   logic       m_ack;
   logic       m_nack;
   logic [2:0] s_valid;
   logic [2:0] s_ready;
   logic       txn_done;
   logic [1:0] sel;
   logic       busy;

   modport slave (
      input  m_valid, m_wdata, s_ready, txn_done,
      output m_ack, m_nack, s_valid, sel, busy
   );

   modport master (
      output m_valid, m_wdata, s_ready, txn_done,
      input  m_ack, m_nack, s_valid, sel, busy
   );
endinterface

// File: rtl/serial_addr_decoder.sv
// Captures the serial device-address prefix of a master request, picks one of three slaves,
// waits for its ready, then routes valid to it and steers the response mux until txn_done.
module serial_addr_decoder #(
   parameter int DEV_ADDR_WIDTH = 4,
   parameter int SLAVE0_ID      = 0,
   parameter int SLAVE1_ID      = 1,
   parameter int SLAVE2_ID      = 2,
   parameter int READY_TIMEOUT  = 16
) (
   input logic                  clk,
   input logic                  rst,
   serial_addr_decoder_if.slave bus
);

   localparam int CW = $clog2(DEV_ADDR_WIDTH + 1);
   localparam int TW = $clog2(READY_TIMEOUT + 1);

   localparam logic [DEV_ADDR_WIDTH-1:0] ID0 = DEV_ADDR_WIDTH'(SLAVE0_ID);
   localparam logic [DEV_ADDR_WIDTH-1:0] ID1 = DEV_ADDR_WIDTH'(SLAVE1_ID);
   localparam logic [DEV_ADDR_WIDTH-1:0] ID2 = DEV_ADDR_WIDTH'(SLAVE2_ID);
   localparam logic [CW-1:0]             CNT_LAST = CW'(DEV_ADDR_WIDTH);
   localparam logic [TW-1:0]             TMO_LAST = TW'(READY_TIMEOUT);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      DECODE,
      WAIT_RDY,
      CONNECT
   } state_t;

   state_t                    state_q,   state_d;
   logic [DEV_ADDR_WIDTH-1:0] shift_q,   shift_d;
   logic [CW-1:0]             bit_cnt_q, bit_cnt_d;
   logic [TW-1:0]             tmo_cnt_q, tmo_cnt_d;
   logic [1:0]                idx_q,     idx_d;
   logic                      m_ack_q,   m_ack_d;
   logic                      m_nack_q,  m_nack_d;
   logic [1:0]                sel_q,     sel_d;
   logic                      busy_q,    busy_d;
   logic                      ready_sel;
   logic [2:0]                s_valid_o;

   // Only the addressed slave's ready matters; idx never holds 3.
   always_comb begin
      case (idx_q)
         2'd1:    ready_sel = bus.s_ready[1];
         2'd2:    ready_sel = bus.s_ready[2];
         default: ready_sel = bus.s_ready[0];
      endcase
   end

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      tmo_cnt_d = tmo_cnt_q;
      idx_d     = idx_q;
      m_ack_d   = 1'b0;
      m_nack_d  = 1'b0;
      sel_d     = sel_q;
      case (state_q)
         IDLE: begin
            if (bus.m_valid) begin
               shift_d   = DEV_ADDR_WIDTH'({shift_q, bus.m_wdata});
               bit_cnt_d = CW'(1);
               state_d   = (DEV_ADDR_WIDTH == 1) ? DECODE : ADDR;
            end
         end
         ADDR: begin
            if (!bus.m_valid) begin
               state_d   = IDLE;
               bit_cnt_d = '0;
               tmo_cnt_d = '0;
            end else begin
               shift_d   = DEV_ADDR_WIDTH'({shift_q, bus.m_wdata});
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q + 1'b1 == CNT_LAST) begin
                  state_d = DECODE;
               end
            end
         end
         DECODE: begin
            bit_cnt_d = '0;
            tmo_cnt_d = '0;
            // Checked in index order so duplicate IDs resolve to the lowest slave.
            if (shift_q == ID0) begin
               idx_d   = 2'd0;
               state_d = WAIT_RDY;
            end else if (shift_q == ID1) begin
               idx_d   = 2'd1;
               state_d = WAIT_RDY;
            end else if (shift_q == ID2) begin
               idx_d   = 2'd2;
               state_d = WAIT_RDY;
            end else begin
               m_nack_d = 1'b1;
               state_d  = IDLE;
            end
         end
         WAIT_RDY: begin
            if (!bus.m_valid) begin
               state_d   = IDLE;
               tmo_cnt_d = '0;
            end else if (ready_sel) begin
               m_ack_d   = 1'b1;
               sel_d     = idx_q;
               state_d   = CONNECT;
               tmo_cnt_d = '0;
            end else if (tmo_cnt_q + 1'b1 == TMO_LAST) begin
               m_nack_d  = 1'b1;
               state_d   = IDLE;
               tmo_cnt_d = '0;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end
         CONNECT: begin
            if (bus.txn_done) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // Valid to the connected slave follows the master with no register stage.
   always_comb begin
      s_valid_o = 3'b000;
      if (state_q == CONNECT && bus.m_valid) begin
         case (idx_q)
            2'd1:    s_valid_o = 3'b010;
            2'd2:    s_valid_o = 3'b100;
            default: s_valid_o = 3'b001;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         tmo_cnt_q <= '0;
         idx_q     <= 2'd0;
         m_ack_q   <= 1'b0;
         m_nack_q  <= 1'b0;
         sel_q     <= 2'd0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         tmo_cnt_q <= tmo_cnt_d;
         idx_q     <= idx_d;
         m_ack_q   <= m_ack_d;
         m_nack_q  <= m_nack_d;
         sel_q     <= sel_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.m_ack   = m_ack_q;
   assign bus.m_nack  = m_nack_q;
   assign bus.sel     = sel_q;
   assign bus.busy    = busy_q;
   assign bus.s_valid = s_valid_o;

endmodule
